// File: rtl/somador_pkg.sv
// rtl/somador_pkg.sv - shared types and constants for the nibble-serial adder controller
package somador_pkg;

  localparam int NIBBLE_W      = 4;
  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/somador4.sv
// rtl/somador4.sv - 4-bit ripple adder with carry in/out, the only arithmetic in the block
module somador4
  import somador_pkg::*;
(
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                CIN,
  output logic [NIBBLE_W-1:0] S,
  output logic                COUT
);

  assign {COUT, S} = {1'b0, A} + {1'b0, B} + {{NIBBLE_W{1'b0}}, CIN};

endmodule

// File: rtl/somador_seq_ctrl.sv
// rtl/somador_seq_ctrl.sv - two-requester round-robin front end sharing one 4-bit adder
module somador_seq_ctrl
  import somador_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             cin0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     a_q, b_q;
  logic                 carry_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 prio_q;
  logic [1:0]           grant;
  logic                 accept;
  logic                 last_nib;
  logic [NIBBLE_W-1:0]  nib_a, nib_b, nib_s;
  logic                 nib_cout;

  // prio_q names the requester that wins a tie: the one not granted last
  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) grant = prio_q ? 2'b10 : 2'b01;
    else                    grant = req_valid;
  end

  assign req_ready = (state == IDLE && rst) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign nib_a    = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b    = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign last_nib = (idx_q == IDX_W'(NIB - 1));

  somador4 u_add (
    .A    (nib_a),
    .B    (nib_b),
    .CIN  (carry_q),
    .S    (nib_s),
    .COUT (nib_cout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = CALC;
      CALC:    if (last_nib)  state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      prio_q   <= 1'b0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_id   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= req_ready[1] ? a1 : a0;
            b_q     <= req_ready[1] ? b1 : b0;
            carry_q <= req_ready[1] ? cin1 : cin0;
            res_id  <= req_ready[1];
            prio_q  <= ~req_ready[1];
            idx_q   <= '0;
          end
        end
        CALC: begin
          res_sum[idx_q*NIBBLE_W +: NIBBLE_W] <= nib_s;
          carry_q <= nib_cout;
          idx_q   <= idx_q + 1'b1;
          if (last_nib) res_cout <= nib_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_somador_seq_ctrl.sv
// tb/tb_somador_seq_ctrl.sv - directed and randomized checks of somador_seq_ctrl against a timeline model
module tb_somador_seq_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             cin0, cin1;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout, res_id, busy;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int two_hot = 0;

  always #5 clk = ~clk;

  somador_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .a0(a0), .b0(b0), .cin0(cin0), .a1(a1), .b1(b1), .cin1(cin1),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .res_id(res_id), .busy(busy)
  );

  always @(negedge clk) if (req_ready === 2'b11) two_hot++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (res_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // tie goes to the favoured requester; a lone request is always granted
  function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic fav);
    if (v == 2'b11) return fav ? 2'b10 : 2'b01;
    return v;
  endfunction

  function automatic logic [WIDTH:0] add_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic c);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
  endfunction

  logic [WIDTH:0] exp_sum;
  logic           exp_id;
  logic           prio_m;
  logic [1:0]     g, er;
  logic [WIDTH+1:0] snap;
  logic           m_idle, ev;
  int lat, n, m_cnt, ops, cycles, seen;
  int bad_v, bad_s, bad_r, bad_b, err_ready, err_valid, err_busy;

  initial begin
    rst = 1'b0; req_valid = 2'b11; res_ready = 1'b0;
    a0 = '0; b0 = '0; cin0 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    prio_m = 1'b0;
    tick(); tick();
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_res_sum",   64'(res_sum),   64'(0));
    chk("rst_res_cout",  64'(res_cout),  64'(0));
    chk("rst_res_id",    64'(res_id),    64'(0));
    rst = 1'b1; req_valid = 2'b00;
    tick();

    // requester 0 directed sum with latency
    a0 = 16'h1234; b0 = 16'h0FFF; cin0 = 1'b0; req_valid = 2'b01; #1;
    chk("d0_grant", 64'(req_ready), 64'(2'b01));
    tick(); req_valid = 2'b00; #1;
    chk("d0_busy_calc", 64'(busy), 64'(1));
    wait_valid(lat);
    chk("d0_latency", 64'(lat + 1), 64'(NIB + 1));
    chk("d0_sum",  64'(res_sum),  64'(16'h2233));
    chk("d0_cout", 64'(res_cout), 64'(0));
    chk("d0_id",   64'(res_id),   64'(0));
    res_ready = 1'b1; tick(); res_ready = 1'b0; #1;
    chk("d0_released", 64'({busy, res_valid}), 64'(0));
    prio_m = 1'b1;

    // requester 1, carry ripples through every nibble
    a1 = 16'hFFFF; b1 = 16'h0000; cin1 = 1'b1; req_valid = 2'b10; #1;
    chk("d1_grant", 64'(req_ready), 64'(2'b10));
    tick(); req_valid = 2'b00;
    wait_valid(lat);
    chk("d1_sum",  64'(res_sum),  64'(16'h0000));
    chk("d1_cout", 64'(res_cout), 64'(1));
    chk("d1_id",   64'(res_id),   64'(1));
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    prio_m = 1'b0;

    // both requesting continuously: grants must alternate
    req_valid = 2'b11; res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a0 = 16'($urandom); b0 = 16'($urandom); cin0 = 1'($urandom);
      a1 = 16'($urandom); b1 = 16'($urandom); cin1 = 1'($urandom);
      #1;
      n = 0;
      while (req_ready === 2'b00 && n < 20) begin tick(); n++; end
      g = req_ready;
      chk("rr_grant", 64'(g), 64'((k % 2) ? 2'b10 : 2'b01));
      exp_sum = g[1] ? add_ref(a1, b1, cin1) : add_ref(a0, b0, cin0);
      tick();
      wait_valid(lat);
      chk("rr_result", 64'({res_cout, res_sum, res_id}), 64'({exp_sum, g[1]}));
      tick();
    end
    chk("rr_never_two_hot", 64'(two_hot), 64'(0));
    req_valid = 2'b00; res_ready = 1'b0; prio_m = 1'b0;

    // result held while the consumer stalls
    a0 = 16'($urandom); b0 = 16'($urandom); cin0 = 1'b1; req_valid = 2'b01; #1;
    exp_sum = add_ref(a0, b0, cin0);
    chk("st_grant", 64'(req_ready), 64'(2'b01));
    tick(); req_valid = 2'b11;
    wait_valid(lat);
    snap = {res_cout, res_sum, res_id};
    chk("st_result", 64'(snap), 64'({exp_sum, 1'b0}));
    bad_v = 0; bad_s = 0; bad_r = 0; bad_b = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (res_valid !== 1'b1) bad_v++;
      if ({res_cout, res_sum, res_id} !== snap) bad_s++;
      if (req_ready !== 2'b00) bad_r++;
      if (busy !== 1'b1) bad_b++;
    end
    chk("st_valid_held", 64'(bad_v), 64'(0));
    chk("st_outputs_stable", 64'(bad_s), 64'(0));
    chk("st_no_ready", 64'(bad_r), 64'(0));
    chk("st_busy", 64'(bad_b), 64'(0));
    req_valid = 2'b00; res_ready = 1'b1; tick(); res_ready = 1'b0; #1;
    chk("st_released", 64'(res_valid), 64'(0));
    tick();
    chk("st_no_replay", 64'({busy, res_valid}), 64'(0));
    prio_m = 1'b1;

    // reset during the second CALC cycle aborts silently
    req_valid = 2'b01; #1;
    chk("ab_grant", 64'(req_ready), 64'(2'b01));
    tick(); req_valid = 2'b00;
    tick();
    chk("ab_busy_calc", 64'(busy), 64'(1));
    rst = 1'b0; req_valid = 2'b11;
    tick();
    chk("ab_idle", 64'({busy, res_valid, req_ready}), 64'(0));
    rst = 1'b1; req_valid = 2'b00;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (res_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    chk("ab_no_result", 64'(seen), 64'(0));
    prio_m = 1'b0;

    // randomized traffic against a cycle-level timeline model
    m_idle = 1'b1; m_cnt = 0; ops = 0; cycles = 0;
    err_ready = 0; err_valid = 0; err_busy = 0;
    while (ops < 1000 && cycles < 40000) begin
      tick(); cycles++;
      req_valid = 2'($urandom_range(0, 3));
      a0 = 16'($urandom); b0 = 16'($urandom); cin0 = 1'($urandom);
      a1 = 16'($urandom); b1 = 16'($urandom); cin1 = 1'($urandom);
      res_ready = 1'($urandom_range(0, 1));
      #1;
      if (!m_idle) m_cnt++;
      ev = !m_idle && (m_cnt >= NIB + 1);
      er = m_idle ? exp_grant(req_valid, prio_m) : 2'b00;
      if (req_ready !== er) err_ready++;
      if (res_valid !== ev) err_valid++;
      if (busy !== !m_idle) err_busy++;
      if (ev && res_ready) begin
        chk("rand_sum", 64'({res_cout, res_sum}), 64'(exp_sum));
        chk("rand_id", 64'(res_id), 64'(exp_id));
        ops++;
        m_idle = 1'b1;
      end else if (er != 2'b00) begin
        exp_id  = er[1];
        exp_sum = er[1] ? add_ref(a1, b1, cin1) : add_ref(a0, b0, cin0);
        prio_m  = ~er[1];
        m_idle  = 1'b0;
        m_cnt   = 0;
      end
    end
    chk("rand_ops_done", 64'(ops), 64'(1000));
    chk("rand_ready_timeline", 64'(err_ready), 64'(0));
    chk("rand_valid_timeline", 64'(err_valid), 64'(0));
    chk("rand_busy_timeline", 64'(err_busy), 64'(0));
    chk("never_two_hot", 64'(two_hot), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
